// File: rtl/hnm_hit_readout_pkg.sv
// Shared HNM geometry and readout state encoding, common to the storage and readout blocks.
package hnm_hit_readout_pkg;

  localparam int ROWINDEXBITS_HNM = 7;
  localparam int COLINDEXBITS_HNM = 5;
  localparam int NROWS_HNM        = 1 << ROWINDEXBITS_HNM;
  localparam int NCOLS_HNM        = 1 << COLINDEXBITS_HNM;
  localparam int ADDRESSBITS      = ROWINDEXBITS_HNM + COLINDEXBITS_HNM;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SCAN  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [ADDRESSBITS-1:0] hit_address(
    input logic [ROWINDEXBITS_HNM-1:0] row,
    input logic [COLINDEXBITS_HNM-1:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/hnm_lowest_bit_encoder.sv
// Combinational lowest-set-bit encoder: index of the least significant 1 and a nonzero flag.
module hnm_lowest_bit_encoder
  import hnm_hit_readout_pkg::*;
#(
  parameter int WIDTH     = NCOLS_HNM,
  parameter int INDEXBITS = COLINDEXBITS_HNM
) (
  input  logic [WIDTH-1:0]     bits,
  output logic [INDEXBITS-1:0] index,
  output logic                 nonzero
);

  // Isolate the lowest set bit as a one-hot word, then OR-reduce per index bit.
  logic [WIDTH-1:0] lowest;
  assign lowest  = bits & (~bits + 1'b1);
  assign nonzero = |bits;

  generate
    for (genvar gi = 0; gi < INDEXBITS; gi++) begin : g_index
      logic [WIDTH-1:0] mask;
      always_comb begin
        mask = '0;
        for (int c = 0; c < WIDTH; c++) begin
          mask[c] = c[gi];
        end
      end
      assign index[gi] = |(lowest & mask);
    end
  endgenerate

endmodule

// File: rtl/hnm_hit_readout.sv
// Sweeps the HNM bitmap row by row and streams every set bit as a {row, col} hit address.
// Optional HNM_CLEAR_ON_READ_EN: zero each row through the write port as the sweep leaves it.
module hnm_hit_readout
  import hnm_hit_readout_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        startRead,
  output logic                        busy,
  output logic                        done,
  output logic [ROWINDEXBITS_HNM-1:0] memReadRowIndex,
  input  logic [NCOLS_HNM-1:0]        memReadData,
  output logic                        memWriteEnable,
  output logic [ROWINDEXBITS_HNM-1:0] memWriteRowIndex,
  output logic [NCOLS_HNM-1:0]        memWriteData,
  output logic [ADDRESSBITS-1:0]      address,
  output logic                        addressValid,
  input  logic                        addressReady,
  output logic [ADDRESSBITS:0]        hitCount
);

  localparam logic [ROWINDEXBITS_HNM-1:0] ROW_LAST = ROWINDEXBITS_HNM'(NROWS_HNM - 1);

  state_t                        state_reg, state_next;
  logic [ROWINDEXBITS_HNM-1:0]   row_reg, row_next;
  logic [NCOLS_HNM-1:0]          buf_reg, buf_next;
  logic [ADDRESSBITS:0]          count_reg, count_next;
  logic [COLINDEXBITS_HNM-1:0]   col;
  logic                          nonzero;

  hnm_lowest_bit_encoder u_encoder (
    .bits    (buf_reg),
    .index   (col),
    .nonzero (nonzero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      row_reg   <= '0;
      buf_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      buf_reg   <= buf_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    buf_next   = buf_reg;
    count_next = count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (startRead) begin
          state_next = ST_FETCH;
          row_next   = '0;
          count_next = '0;
        end
      end
      ST_FETCH: state_next = ST_WAIT;
      ST_WAIT: begin
        buf_next   = memReadData;
        state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (nonzero) begin
          // x & (x-1) drops exactly the lowest set bit, i.e. the hit just accepted.
          if (addressReady) begin
            buf_next   = buf_reg & (buf_reg - 1'b1);
            count_next = count_reg + 1'b1;
          end
        end else if (row_reg == ROW_LAST) begin
          state_next = ST_DONE;
        end else begin
          row_next   = row_reg + 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy            = (state_reg != ST_IDLE);
  assign done            = (state_reg == ST_DONE);
  assign memReadRowIndex = row_reg;
  assign addressValid    = (state_reg == ST_SCAN) && nonzero;
  assign address         = addressValid ? hit_address(row_reg, col) : '0;
  assign hitCount        = count_reg;
  assign memWriteData    = '0;

`ifdef HNM_CLEAR_ON_READ_EN
  assign memWriteEnable   = (state_reg == ST_SCAN) && !nonzero;
  assign memWriteRowIndex = row_reg;
`else
  assign memWriteEnable   = 1'b0;
  assign memWriteRowIndex = '0;
`endif

endmodule

// File: tb/tb_hnm_hit_readout.sv
// Bench for hnm_hit_readout: table-driven sweeps, randomized sweeps against a bitmap scan model,
// and hand-written reset-abort / full-memory sequences.
module tb_hnm_hit_readout;
  import hnm_hit_readout_pkg::*;

`ifdef HNM_CLEAR_ON_READ_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic                        clock = 1'b0;
  logic                        reset;
  logic                        startRead;
  logic                        busy;
  logic                        done;
  logic [ROWINDEXBITS_HNM-1:0] memReadRowIndex;
  logic [NCOLS_HNM-1:0]        memReadData;
  logic                        memWriteEnable;
  logic [ROWINDEXBITS_HNM-1:0] memWriteRowIndex;
  logic [NCOLS_HNM-1:0]        memWriteData;
  logic [ADDRESSBITS-1:0]      address;
  logic                        addressValid;
  logic                        addressReady;
  logic [ADDRESSBITS:0]        hitCount;

  hnm_hit_readout dut (
    .clock            (clock),
    .reset            (reset),
    .startRead        (startRead),
    .busy             (busy),
    .done             (done),
    .memReadRowIndex  (memReadRowIndex),
    .memReadData      (memReadData),
    .memWriteEnable   (memWriteEnable),
    .memWriteRowIndex (memWriteRowIndex),
    .memWriteData     (memWriteData),
    .address          (address),
    .addressValid     (addressValid),
    .addressReady     (addressReady),
    .hitCount         (hitCount)
  );

  always #5 clock = ~clock;

  // HNM model: one-cycle registered read, bench load port, DUT write port.
  logic [NCOLS_HNM-1:0]        hnm [NROWS_HNM];
  logic                        mem_clr = 1'b0;
  logic                        load_en = 1'b0;
  logic [ROWINDEXBITS_HNM-1:0] load_row = '0;
  logic [NCOLS_HNM-1:0]        load_data = '0;

  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < NROWS_HNM; i++) hnm[i] <= '0;
    end else if (load_en) begin
      hnm[load_row] <= load_data;
    end else if (memWriteEnable) begin
      hnm[memWriteRowIndex] <= memWriteData;
    end
    memReadData <= hnm[memReadRowIndex];
  end

  int tests = 0;
  int fails = 0;

  logic [ADDRESSBITS-1:0] exp_q[$];
  logic [ADDRESSBITS-1:0] accepted[$];
  logic [NCOLS_HNM-1:0]   snap [NROWS_HNM];
  bit                     stall_prev;
  int                     wr_count;
  int                     wr_bad;
  int                     last_hits;

  typedef struct {
    int                     ra;
    logic [NCOLS_HNM-1:0]   da;
    int                     rb;
    logic [NCOLS_HNM-1:0]   db;
    int                     mode;
    bit                     start_mid;
    bit                     start_in_done;
    int                     exp_hits;
    int                     exp_cycles;
    logic [ADDRESSBITS-1:0] exp_first;
    logic [ADDRESSBITS-1:0] exp_last;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic mem_clear();
    @(posedge clock); #1 mem_clr = 1'b1;
    @(posedge clock); #1 mem_clr = 1'b0;
  endtask

  task automatic mem_load(input int r, input logic [NCOLS_HNM-1:0] d);
    @(posedge clock); #1;
    load_en = 1'b1; load_row = ROWINDEXBITS_HNM'(r); load_data = d;
    @(posedge clock); #1 load_en = 1'b0;
  endtask

  // Reference: every set bit of the bitmap, rows ascending then columns ascending.
  task automatic build_expected();
    exp_q.delete();
    for (int r = 0; r < NROWS_HNM; r++)
      for (int c = 0; c < NCOLS_HNM; c++)
        if (hnm[r][c]) exp_q.push_back(ADDRESSBITS'(r * NCOLS_HNM + c));
  endtask

  task automatic monitor_cycle();
    if (addressValid) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL extra_hit: got 0x%0h, required no further hit", address);
      end else begin
        check("hit_addr", 32'(address), 32'(exp_q[0]));
        if (addressReady) begin
          accepted.push_back(address);
          void'(exp_q.pop_front());
        end
      end
    end else if (stall_prev) begin
      tests++; fails++;
      $display("FAIL valid_drop: got addressValid=0, required 1 while stalled");
    end
    stall_prev = addressValid && !addressReady;
    if (memWriteData !== '0) wr_bad++;
    if (memWriteEnable === 1'b1) begin
      if (!CLEAR_EN || memWriteRowIndex !== ROWINDEXBITS_HNM'(wr_count)) wr_bad++;
      wr_count++;
    end else if (memWriteEnable !== 1'b0 || (!CLEAR_EN && memWriteRowIndex !== '0)) begin
      wr_bad++;
    end
  endtask

  task automatic run_sweep(input int mode, input bit start_mid, input bit start_in_done,
                           output int done_cyc);
    int n_exp;
    int post_bad;
    int mem_bad;
    build_expected();
    n_exp = exp_q.size();
    for (int r = 0; r < NROWS_HNM; r++) snap[r] = hnm[r];
    accepted.delete();
    stall_prev = 0; wr_count = 0; wr_bad = 0; done_cyc = -1;
    @(posedge clock); #1 startRead = 1'b1;
    @(posedge clock); #1 startRead = 1'b0;
    for (int cyc = 1; cyc <= 20000; cyc++) begin
      addressReady = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      startRead    = start_mid && (cyc == 50 || cyc == 200);
      @(negedge clock);
      if (cyc == 1) check("busy_first", 32'(busy), 1);
      monitor_cycle();
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clock); #1;
    end
    if (done_cyc < 0) begin
      tests++; fails++;
      $display("FAIL sweep_timeout: got no done, required done within 20000 cycles");
    end
    check("busy_in_done", 32'(busy), 1);
    check("hitcount", 32'(hitCount), 32'(n_exp));
    check("hits_left", 32'(exp_q.size()), 0);
    if (start_in_done) startRead = 1'b1;
    @(posedge clock); #1 startRead = 1'b0;
    post_bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0 || addressValid !== 1'b0) post_bad++;
      @(posedge clock); #1;
    end
    check("idle_after_done", 32'(post_bad), 0);
    check("hitcount_hold", 32'(hitCount), 32'(n_exp));
    check("write_count", 32'(wr_count), CLEAR_EN ? 32'(NROWS_HNM) : 32'd0);
    check("write_port", 32'(wr_bad), 0);
    mem_bad = 0;
    for (int r = 0; r < NROWS_HNM; r++)
      if (hnm[r] !== (CLEAR_EN ? '0 : snap[r])) mem_bad++;
    check("mem_after", 32'(mem_bad), 0);
    last_hits = n_exp;
    $display("[TB] sweep mode=%0d hits=%0d done_cycle=%0d hitCount=%0d", mode, n_exp, done_cyc,
             hitCount);
  endtask

  initial begin
    int dc;
    bit found;
    logic [ADDRESSBITS-1:0] first_a, last_a;

    vecs[0] = '{0, 32'h0,        0,   32'h0,  0, 1'b0, 1'b0, 0,  385, 12'h000, 12'h000};
    vecs[1] = '{0, 32'h80000001, 127, 32'h10, 0, 1'b0, 1'b0, 3,  388, 12'h000, 12'hFE4};
    vecs[2] = '{5, 32'h0000000F, 0,   32'h0,  1, 1'b0, 1'b0, 4,  0,   12'h0A0, 12'h0A3};
    vecs[3] = '{3, 32'hFFFFFFFF, 9,   32'h1,  2, 1'b1, 1'b0, 33, 0,   12'h060, 12'h120};
    vecs[4] = '{127, 32'hFFFFFFFF, 0, 32'h0,  0, 1'b0, 1'b1, 32, 417, 12'hFE0, 12'hFFF};

    reset = 1'b1; startRead = 1'b0; addressReady = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(addressValid), 0);
    check("rst_address", 32'(address), 0);
    check("rst_hitcount", 32'(hitCount), 0);
    check("rst_wen", 32'(memWriteEnable), 0);
    check("rst_rdrow", 32'(memReadRowIndex), 0);
    mem_clear();
    @(posedge clock); #1 reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      mem_clear();
      mem_load(vecs[i].ra, vecs[i].da);
      mem_load(vecs[i].rb, vecs[i].db);
      run_sweep(vecs[i].mode, vecs[i].start_mid, vecs[i].start_in_done, dc);
      check("vec_hits", 32'(hitCount), 32'(vecs[i].exp_hits));
      if (vecs[i].exp_cycles != 0) check("vec_cycles", 32'(dc), 32'(vecs[i].exp_cycles));
      if (vecs[i].exp_hits > 0) begin
        first_a = (accepted.size() > 0) ? accepted[0] : 'x;
        last_a  = (accepted.size() > 0) ? accepted[accepted.size()-1] : 'x;
        check("vec_first", 32'(first_a), 32'(vecs[i].exp_first));
        check("vec_last", 32'(last_a), 32'(vecs[i].exp_last));
      end
    end

    // Randomized bitmaps, then a re-sweep of whatever the first sweep left behind.
    for (int k = 0; k < 4; k++) begin
      int prev;
      mem_clear();
      for (int r = 0; r < NROWS_HNM; r++)
        if ($urandom_range(0, 3) == 0) mem_load(r, $urandom & $urandom);
      run_sweep(int'($urandom_range(0, 2)), 1'b0, 1'b0, dc);
      prev = last_hits;
      run_sweep(0, 1'b0, 1'b0, dc);
      check("resweep_hits", 32'(hitCount), CLEAR_EN ? 32'd0 : 32'(prev));
      check("resweep_cycles", 32'(dc), CLEAR_EN ? 32'd385 : 32'(385 + prev));
    end

    // Reset abort while row 5 bit 1 is on offer.
    mem_clear();
    mem_load(5, 32'h0000000F);
    mem_load(9, 32'h00000003);
    @(posedge clock); #1 startRead = 1'b1;
    @(posedge clock); #1 startRead = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      addressReady = 1'b1;
      @(negedge clock);
      if (addressValid && address == 12'h0A1) begin
        found = 1;
        break;
      end
      @(posedge clock); #1;
    end
    check("abort_reached", 32'(found), 1);
    #1 reset = 1'b1;
    #1;
    check("abort_valid", 32'(addressValid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_hitcount", 32'(hitCount), 0);
    check("abort_wen", 32'(memWriteEnable), 0);
    check("abort_row5_kept", 32'(hnm[5]), 32'h0000000F);
    @(posedge clock); #1 reset = 1'b0;
    run_sweep(0, 1'b0, 1'b0, dc);
    check("after_abort_hits", 32'(hitCount), 6);

    // Every bit set: largest hitCount and longest sweep.
    for (int r = 0; r < NROWS_HNM; r++) mem_load(r, 32'hFFFFFFFF);
    run_sweep(0, 1'b0, 1'b0, dc);
    check("full_hits", 32'(hitCount), 32'd4096);
    check("full_cycles", 32'(dc), 32'(3 * 128 + 4096 + 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
